// File: rtl/cluster_pkg.sv
// ============================================================================
// Module : cluster_pkg
// Brief  : Shared sizes, cluster word type and FSM state type for the
//          cluster unpacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cluster_pkg;

  localparam int MXSBITS        = 1536;
  localparam int MXADRB         = 11;
  localparam int MXCNTB         = 3;
  localparam int MXCLUSTERS     = 8;
  localparam int PARTITION_PADS = 192;
  localparam int SLOTB          = $clog2(MXCLUSTERS + 1);

  localparam logic [MXADRB-1:0] INVALID_ADR = 11'h7FF;

  typedef struct packed {
    logic [MXADRB-1:0] adr;
    logic [MXCNTB-1:0] cnt;
  } cluster_word_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Last pad of the eta partition that contains adr.
  function automatic logic [MXADRB:0] partition_last(input logic [MXADRB-1:0] adr);
    int part;
    part = int'(adr) / PARTITION_PADS;
    return (MXADRB + 1)'((part + 1) * PARTITION_PADS - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cluster_unpacker_if.sv
// ============================================================================
// Module : cluster_unpacker_if
// Brief  : Cluster word bus from the packer side into the unpacker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cluster_unpacker_if;
  import cluster_pkg::*;

  logic              frame_start;
  logic              clst_valid;
  logic [MXADRB-1:0] clst_adr;
  logic [MXCNTB-1:0] clst_cnt;

  modport master (output frame_start, clst_valid, clst_adr, clst_cnt);
  modport slave  (input  frame_start, clst_valid, clst_adr, clst_cnt);

endinterface

`default_nettype wire

// File: rtl/cluster_mask_gen.sv
// ============================================================================
// Module : cluster_mask_gen
// Brief  : Expands one cluster word into a pad mask plus clip flag.
//          CLUSTER_UNPACKER_PARTITION_CLIP_EN clips at the partition end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cluster_mask_gen
  import cluster_pkg::*;
(
  input  cluster_word_t       word,
  output logic [MXSBITS-1:0]  mask,
  output logic                clip
);

  logic              in_range;
  logic [MXADRB:0]   first_pad;
  logic [MXADRB:0]   last_pad;
  logic [MXADRB:0]   limit;

  always_comb begin
    in_range  = (word.adr < MXADRB'(MXSBITS));
    first_pad = {1'b0, word.adr};
    last_pad  = first_pad + (MXADRB + 1)'(word.cnt);
`ifdef CLUSTER_UNPACKER_PARTITION_CLIP_EN
    limit     = partition_last(word.adr);
`else
    limit     = (MXADRB + 1)'(MXSBITS - 1);
`endif
    clip      = in_range && (last_pad > limit);
  end

  for (genvar i = 0; i < MXSBITS; i++) begin : g_bit
    localparam logic [MXADRB:0] c_pad = (MXADRB + 1)'(i);
    assign mask[i] = in_range && (c_pad >= first_pad) && (c_pad <= last_pad)
                     && (c_pad <= limit);
  end

endmodule

`default_nettype wire

// File: rtl/cluster_unpacker.sv
// ============================================================================
// Module : cluster_unpacker
// Brief  : Rebuilds the S-bit pad bitmap from up to MXCLUSTERS cluster words
//          per frame. Option: CLUSTER_UNPACKER_PARTITION_CLIP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cluster_unpacker
  import cluster_pkg::*;
(
  input  logic                clock4x,
  input  logic                reset_n,
  cluster_unpacker_if.slave   bus,
  output logic [MXSBITS-1:0]  vpfs_out,
  output logic                latch_out,
  output logic                short_frame,
  output logic                orphan_err,
  output logic                clip_err
);

  localparam logic [SLOTB-1:0] SLOT_LAST = SLOTB'(MXCLUSTERS - 1);

  cluster_word_t        word;
  logic [MXSBITS-1:0]   mask;
  logic                 clip;

  state_t               state_q,  state_d;
  logic [MXSBITS-1:0]   build_q,  build_d;
  logic [MXSBITS-1:0]   vpfs_q,   vpfs_d;
  logic [SLOTB-1:0]     slot_q,   slot_d;
  logic                 latch_q,  latch_d;
  logic                 short_q,  short_d;
  logic                 orphan_q, orphan_d;
  logic                 clip_q,   clip_d;

  assign word = '{adr: bus.clst_adr, cnt: bus.clst_cnt};

  cluster_mask_gen u_mask_gen (
    .word (word),
    .mask (mask),
    .clip (clip)
  );

  always_comb begin
    state_d  = state_q;
    build_d  = build_q;
    vpfs_d   = vpfs_q;
    slot_d   = slot_q;
    latch_d  = 1'b0;
    short_d  = 1'b0;
    orphan_d = orphan_q;
    clip_d   = clip_q;
    if (bus.clst_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.frame_start) begin
            build_d = mask;
            slot_d  = SLOTB'(1);
            clip_d  = clip_q | clip;
            state_d = ST_COLLECT;
          end else begin
            orphan_d = 1'b1;
          end
        end
        ST_COLLECT: begin
          clip_d = clip_q | clip;
          if (bus.frame_start) begin
            // Early frame start closes the old frame and opens the new one.
            vpfs_d  = build_q;
            latch_d = 1'b1;
            short_d = 1'b1;
            build_d = mask;
            slot_d  = SLOTB'(1);
          end else if (slot_q == SLOT_LAST) begin
            vpfs_d  = build_q | mask;
            latch_d = 1'b1;
            build_d = '0;
            slot_d  = '0;
            state_d = ST_IDLE;
          end else begin
            build_d = build_q | mask;
            slot_d  = slot_q + SLOTB'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock4x) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      build_q  <= '0;
      vpfs_q   <= '0;
      slot_q   <= '0;
      latch_q  <= 1'b0;
      short_q  <= 1'b0;
      orphan_q <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      build_q  <= build_d;
      vpfs_q   <= vpfs_d;
      slot_q   <= slot_d;
      latch_q  <= latch_d;
      short_q  <= short_d;
      orphan_q <= orphan_d;
      clip_q   <= clip_d;
    end
  end

  assign vpfs_out    = vpfs_q;
  assign latch_out   = latch_q;
  assign short_frame = short_q;
  assign orphan_err  = orphan_q;
  assign clip_err    = clip_q;

endmodule

`default_nettype wire

// File: tb/tb_cluster_unpacker.sv
// ============================================================================
// Module : tb_cluster_unpacker
// Brief  : Self-checking bench for cluster_unpacker; reference model pushes
//          expected bitmaps, the monitor pops them on latch_out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cluster_unpacker;
  import cluster_pkg::*;

  typedef struct {
    bit fs;
    bit v;
    int adr;
    int cnt;
  } w_t;

  typedef struct {
    logic [MXSBITS-1:0] bits;
    bit                 short_f;
    int                 cyc;
  } exp_t;

  logic                clock4x = 1'b0;
  logic                reset_n = 1'b0;
  logic [MXSBITS-1:0]  vpfs_out;
  logic                latch_out;
  logic                short_frame;
  logic                orphan_err;
  logic                clip_err;

  cluster_unpacker_if bus ();

  cluster_unpacker dut (
    .clock4x     (clock4x),
    .reset_n     (reset_n),
    .bus         (bus),
    .vpfs_out    (vpfs_out),
    .latch_out   (latch_out),
    .short_frame (short_frame),
    .orphan_err  (orphan_err),
    .clip_err    (clip_err)
  );

  always #3 clock4x = ~clock4x;

  int cyc = 0;
  always @(posedge clock4x) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t               sb[$];
  bit                 m_collect;
  int                 m_slot;
  logic [MXSBITS-1:0] m_build;
  bit                 m_orphan;
  bit                 m_clip;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic chk_map(input string name, input logic [MXSBITS-1:0] act,
                         input logic [MXSBITS-1:0] req);
    int first;
    checks++;
    if (act !== req) begin
      errors++;
      first = -1;
      for (int i = MXSBITS - 1; i >= 0; i--) if (act[i] !== req[i]) first = i;
      $display("FAIL %s: bitmap differs at pad %0d, got %0d ones expected %0d ones",
               name, first, $countones(act), $countones(req));
    end
  endtask

  function automatic logic [MXSBITS-1:0] ref_mask(input int adr, input int cnt,
                                                   output bit clipped);
    logic [MXSBITS-1:0] m;
    int lim;
    m = '0;
    clipped = 0;
    if (adr < MXSBITS) begin
      lim = MXSBITS - 1;
`ifdef CLUSTER_UNPACKER_PARTITION_CLIP_EN
      lim = (adr / PARTITION_PADS) * PARTITION_PADS + PARTITION_PADS - 1;
`endif
      for (int k = 0; k <= cnt; k++) begin
        if (adr + k <= lim) m[adr + k] = 1'b1;
        else clipped = 1;
      end
    end
    return m;
  endfunction

  task automatic model_word(input w_t w);
    logic [MXSBITS-1:0] m;
    bit c;
    exp_t e;
    m = ref_mask(w.adr, w.cnt, c);
    if (!m_collect) begin
      if (w.fs) begin
        m_build = m; m_slot = 1; m_collect = 1; m_clip |= c;
      end else begin
        m_orphan = 1;
      end
    end else if (w.fs) begin
      e.bits = m_build; e.short_f = 1; e.cyc = cyc + 1;
      sb.push_back(e);
      m_build = m; m_slot = 1; m_clip |= c;
    end else begin
      m_build |= m; m_slot++; m_clip |= c;
      if (m_slot == MXCLUSTERS) begin
        e.bits = m_build; e.short_f = 0; e.cyc = cyc + 1;
        sb.push_back(e);
        m_collect = 0; m_slot = 0; m_build = '0;
      end
    end
  endtask

  task automatic drive(input w_t w);
    @(posedge clock4x); #1;
    bus.frame_start = w.fs;
    bus.clst_valid  = w.v;
    bus.clst_adr    = MXADRB'(w.adr);
    bus.clst_cnt    = MXCNTB'(w.cnt);
    if (w.v) model_word(w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock4x); #1;
      bus.frame_start = 0; bus.clst_valid = 0;
      bus.clst_adr = INVALID_ADR; bus.clst_cnt = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock4x); #1;
    reset_n = 0;
    bus.frame_start = 0; bus.clst_valid = 0;
    m_collect = 0; m_slot = 0; m_build = '0; m_orphan = 0; m_clip = 0;
    idle(2);
    reset_n = 1;
  endtask

  // Scoreboard monitor: pop on latch, flag late/missing and spurious latches.
  always @(negedge clock4x) begin
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL latch_missing: no latch_out at cycle %0d expected at %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (latch_out) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL latch_spurious: latch_out=1 at cycle %0d expected 0", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latch_cycle", cyc, e.cyc);
          chk_map("vpfs_out", vpfs_out, e.bits);
          chk("short_frame", int'(short_frame), int'(e.short_f));
        end
      end else if (short_frame) begin
        checks++; errors++;
        $display("FAIL short_alone: short_frame=1 latch_out=0 expected short_frame=0");
      end
    end
  end

  localparam int FILL = 2047;
  w_t vec [32];

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) drive(vec[i]);
  endtask

  initial begin
    logic [MXSBITS-1:0] want;
    w_t w;
    int nw;

    // Full frame 0..7, short frame 8..18, partition-edge frame 19..26.
    vec[0] = '{1, 1, 5, 2};
    for (int i = 1; i < 8; i++) vec[i] = '{0, 1, FILL, 0};
    vec[8]  = '{1, 1, 100, 0};
    vec[9]  = '{0, 1, 200, 1};
    vec[10] = '{0, 1, 300, 7};
    vec[11] = '{1, 1, 10, 0};
    for (int i = 12; i < 19; i++) vec[i] = '{0, 1, FILL, 0};
    vec[19] = '{1, 1, 190, 4};
    for (int i = 20; i < 27; i++) vec[i] = '{0, 1, FILL, 0};
    for (int i = 27; i < 32; i++) vec[i] = '{0, 0, FILL, 0};

    bus.frame_start = 0; bus.clst_valid = 0;
    bus.clst_adr = INVALID_ADR; bus.clst_cnt = '0;
    do_reset();
    @(negedge clock4x);
    chk("reset_vpfs_ones", $countones(vpfs_out), 0);
    chk("reset_latch", int'(latch_out), 0);
    chk("reset_short", int'(short_frame), 0);
    chk("reset_orphan", int'(orphan_err), 0);
    chk("reset_clip", int'(clip_err), 0);

    run_vec(0, 7);
    idle(2);
    @(negedge clock4x);
    want = '0; want[7:5] = 3'b111;
    chk_map("full_frame_bits", vpfs_out, want);
    chk("full_frame_latch_gone", int'(latch_out), 0);

    run_vec(8, 18);
    idle(2);
    @(negedge clock4x);
    want = '0; want[10] = 1'b1;
    chk_map("next_frame_bit10", vpfs_out, want);
    chk("no_clip_yet", int'(clip_err), 0);

    run_vec(19, 26);
    idle(2);
    @(negedge clock4x);
`ifdef CLUSTER_UNPACKER_PARTITION_CLIP_EN
    chk("partition_clip", int'(clip_err), 1);
    chk("partition_ones", $countones(vpfs_out), 2);
`else
    chk("partition_span_clip", int'(clip_err), 0);
    chk("partition_span_ones", $countones(vpfs_out), 5);
`endif

    // Chamber-edge clip.
    drive('{1, 1, 1534, 7});
    for (int i = 1; i < 8; i++) drive('{0, 1, FILL, 0});
    idle(2);
    @(negedge clock4x);
    chk("edge_clip", int'(clip_err), 1);
    want = '0; want[1535:1534] = 2'b11;
    chk_map("edge_bits", vpfs_out, want);

    // Orphan word in IDLE.
    chk("orphan_before", int'(orphan_err), 0);
    drive('{0, 1, 50, 0});
    idle(2);
    @(negedge clock4x);
    chk("orphan_set", int'(orphan_err), int'(m_orphan));

    // Frame with 3-cycle gaps between valid words.
    drive('{1, 1, 600, 3});
    for (int i = 1; i < 8; i++) begin
      idle(3);
      drive('{0, 1, 600 + 20 * i, i % 8});
    end
    idle(3);

    // Reset mid-frame after 4 words: no latch, bitmap cleared.
    drive('{1, 1, 700, 1});
    for (int i = 1; i < 4; i++) drive('{0, 1, 710 + i, 0});
    do_reset();
    @(negedge clock4x);
    chk("midreset_vpfs_ones", $countones(vpfs_out), 0);
    chk("midreset_latch", int'(latch_out), 0);
    chk("midreset_orphan", int'(orphan_err), 0);
    run_vec(0, 7);
    idle(3);

    // Random frames of 1..8 words, some short, with random gaps.
    for (int f = 0; f < 20; f++) begin
      nw = (f == 19) ? MXCLUSTERS : int'($urandom_range(1, MXCLUSTERS));
      for (int k = 0; k < nw; k++) begin
        w.fs  = (k == 0);
        w.v   = 1;
        w.adr = ($urandom_range(0, 9) == 0) ? FILL : int'($urandom_range(0, MXSBITS - 1));
        w.cnt = int'($urandom_range(0, 7));
        drive(w);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    idle(4);
    @(negedge clock4x);
    chk("clip_sticky_model", int'(clip_err), int'(m_clip));
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cluster_unpacker.md
Name: cluster_unpacker

Overview:
- Receive-side decoder for the cluster packer output.
- Takes one cluster word per clock4x cycle (11-bit address, 3-bit count), up to 8 per frame, one frame every 50 ns (two BX).
- Rebuilds the 1536-bit S-bit valid-pad bitmap and publishes it with a single-cycle latch pulse.
- Used on the backend and in loopback benches to check packer output against the original S-bits.

Parameters:
- MXSBITS, 1536, bitmap width (pads per chamber)
- MXADRB, 11, cluster address width
- MXCNTB, 3, cluster count width; cluster size = cnt+1
- MXCLUSTERS, 8, cluster slots per frame
- PARTITION_PADS, 192, pads per eta partition; used only by the optional feature

Ports:
- clock4x  in  1  160 MHz fabric clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- frame_start  in  1  marks the first cluster word of a frame; qualified by clst_valid
- clst_valid  in  1  cluster word present this cycle
- clst_adr  in  11  cluster start pad; values >= MXSBITS mean "no cluster"
- clst_cnt  in  3  cluster size minus one
- vpfs_out  out  1536  reconstructed bitmap, held between latches
- latch_out  out  1  one-cycle pulse when vpfs_out updates
- short_frame  out  1  one-cycle pulse alongside latch_out when the frame held fewer than MXCLUSTERS words
- orphan_err  out  1  sticky; set when a word arrives outside a frame
- clip_err  out  1  sticky; set when a cluster runs past its clip boundary

Behaviour:
- Reset (reset_n=0 at a clock edge) clears:
  - vpfs_out, build buffer, slot counter: all 0
  - latch_out, short_frame, orphan_err, clip_err: all 0
  - state: IDLE
  - Reset mid-frame discards the partial frame; no latch_out is produced.
- States:
  - IDLE: waits for clst_valid & frame_start.
  - COLLECT: accumulates cluster words.
- IDLE behaviour:
  - clst_valid & frame_start: OR the word's mask into a cleared build buffer, slot=1, go to COLLECT.
  - clst_valid & !frame_start: word dropped, orphan_err set.
- COLLECT behaviour:
  - clst_valid & !frame_start: OR the mask into the build buffer, slot+1.
  - When the accepted word is slot MXCLUSTERS (8th): next cycle vpfs_out = build | mask, latch_out=1, state IDLE.
  - clst_valid & frame_start (new frame before 8 words): publish the current buffer with latch_out=1 and short_frame=1. The same cycle loads a fresh buffer with the new word's mask, slot=1, stays in COLLECT.
  - Cycles with clst_valid=0 are idle gaps. Slots are not consumed and there is no timeout.
- Latency: latch_out asserts exactly 1 cycle after the edge that accepts the final word.
- Mask generation:
  - Bits adr .. adr+cnt are set.
  - adr >= MXSBITS: empty mask, but the word still consumes a slot.
  - Pads beyond MXSBITS-1 are dropped and clip_err is set.
- Overlapping clusters OR together; there is no error for overlap.
- vpfs_out holds its value until the next latch_out.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: CLUSTER_UNPACKER_PARTITION_CLIP_EN.
- Defined: expansion clips at the end of the start pad's partition, (adr/PARTITION_PADS+1)*PARTITION_PADS-1. Dropped pads set clip_err.
- Undefined: clipping only at MXSBITS-1; a cluster may span partitions.

Decomposition:
- Shared package cluster_pkg:
  - MXSBITS, MXADRB, MXCNTB, MXCLUSTERS, PARTITION_PADS
  - invalid-address constant 11'h7FF
  - cluster word typedef {adr, cnt}
- One sub-module: cluster_mask_gen.
  - Combinational: adr, cnt -> 1536-bit mask plus clip flag.
  - Honours the macro.

Test Plan:
- Full frame: frame_start with adr=5,cnt=2, then 7 words adr=0x7FF -> latch_out 1 cycle after the 8th word; vpfs_out bits 5..7 only; short_frame=0.
- Short frame: 3 words (adr=100/cnt=0, 200/1, 300/7), then frame_start with adr=10/cnt=0 -> latch_out and short_frame pulse; bits 100, 200-201, 300-307 set. The next frame then contains bit 10.
- Clipping: adr=1534,cnt=7 -> bits 1534,1535 set; clip_err=1. With the macro, adr=190,cnt=4 -> bits 190,191 only; clip_err=1.
- Orphan/gaps: clst_valid without frame_start in IDLE -> dropped, orphan_err=1. A frame with clst_valid gaps of 3 cycles -> still publishes after 8 valid words.
- Reset mid-frame: reset_n low after 4 words -> no latch_out; vpfs_out=0; next full frame decodes correctly.
- Loopback: random bitmaps through the cluster packer into this block -> vpfs_out equals the input when there are 8 or fewer clusters of size 8 or less.
